// File: rtl/axi_slice_dc_pwr_ctrl.sv
// -----------------------------------------------------------------------------
// axi_slice_dc_pwr_ctrl
// Power sequencer for an AXI clock-domain-crossing slice. It tracks the
// outstanding write/read transactions seen on the master side. On a sleep
// request it drains the slice, then gates the slice clock. When the macro
// below is defined, it can also force isolation after a drain timeout.
//
// Optional feature: define AXI_SLICE_DC_PWR_CTRL_TIMEOUT_EN to compile in the
// drain-timeout / forced-isolation path. Without it, DRAIN waits forever and
// isolate_o is tied low.
//
// Parameters:
//   MAX_OUTST      max in-flight transactions per direction
//   IDLE_CYCLES    consecutive idle DRAIN cycles required before clock-down
//   TIMEOUT_CYCLES DRAIN cycles allowed before forced isolation
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   sleep_req_i        level request to power down the slice
//   incoming_req_i     slice-side aw/ar/w valid pending
//   aw_hs_i, b_hs_i    write issue / write response handshakes
//   ar_hs_i, r_last_hs_i read issue / last read beat handshakes
//   clock_down_o       slice clock gate
//   isolate_o          slice isolation
//   sleep_ack_o        slice quiescent and gated
//   wr_outst_o, rd_outst_o outstanding transaction counts
//   error_o            sticky counter fault or drain timeout
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ACTIVE   | slice running normally
// DRAIN    | sleep requested, waiting for IDLE_CYCLES consecutive idle cycles
// ISOLATE  | drain timed out, one cycle of forced isolation
// SLEEP    | slice clock gated, sleep acknowledged
// WAKE     | one-cycle exit from SLEEP back to ACTIVE
// -----------------------------------------------------------------------------
module axi_slice_dc_pwr_ctrl #(
  parameter int MAX_OUTST      = 15,
  parameter int IDLE_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             sleep_req_i,
  input  logic                             incoming_req_i,
  input  logic                             aw_hs_i,
  input  logic                             ar_hs_i,
  input  logic                             b_hs_i,
  input  logic                             r_last_hs_i,
  output logic                             clock_down_o,
  output logic                             isolate_o,
  output logic                             sleep_ack_o,
  output logic [$clog2(MAX_OUTST+1)-1:0]   wr_outst_o,
  output logic [$clog2(MAX_OUTST+1)-1:0]   rd_outst_o,
  output logic                             error_o
);

  localparam int CW = $clog2(MAX_OUTST+1);
  localparam int IW = $clog2(IDLE_CYCLES+1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_OUTST);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES-1);

  typedef enum logic [2:0] {
    ST_ACTIVE,
    ST_DRAIN,
    ST_ISOLATE,
    ST_SLEEP,
    ST_WAKE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic [CW:0]   wr_step, rd_step;
  logic [IW-1:0] idle_cnt;
  logic          idle, idle_done, timeout_hit;
  logic          clock_down_q, sleep_ack_q, error_q;

  // Returns {fault, next_count}; simultaneous up/down holds the count.
  function automatic logic [CW:0] step_cnt(input logic [CW-1:0] cnt,
                                           input logic up, input logic dn);
    logic [CW:0] r;
    r = {1'b0, cnt};
    if (up && !dn) begin
      if (cnt == CNT_MAX) r[CW] = 1'b1;
      else                r = {1'b0, cnt + 1'b1};
    end else if (dn && !up) begin
      if (cnt == '0) r[CW] = 1'b1;
      else           r = {1'b0, cnt - 1'b1};
    end
    return r;
  endfunction

  assign wr_step   = step_cnt(wr_cnt, aw_hs_i, b_hs_i);
  assign rd_step   = step_cnt(rd_cnt, ar_hs_i, r_last_hs_i);
  assign idle      = !incoming_req_i && (wr_cnt == '0) && (rd_cnt == '0);
  // Decided on the cycle carrying the last required idle sample.
  assign idle_done = idle && (idle_cnt == IDLE_LAST);

`ifdef AXI_SLICE_DC_PWR_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES-1);
  logic [TW-1:0] to_cnt;
  logic          isolate_q;

  assign timeout_hit = (to_cnt == TO_LAST);
  assign isolate_o   = isolate_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt    <= '0;
      isolate_q <= 1'b0;
    end else begin
      to_cnt    <= (state == ST_DRAIN) ? to_cnt + 1'b1 : '0;
      // Isolation stays on through a SLEEP that was entered via ISOLATE.
      isolate_q <= (state_nxt == ST_ISOLATE) ||
                   ((state_nxt == ST_SLEEP) &&
                    ((state == ST_ISOLATE) || ((state == ST_SLEEP) && isolate_q)));
    end
  end
`else
  // No timeout path: the comparison is constant false, DRAIN never times out.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
  assign isolate_o   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACTIVE:  if (sleep_req_i) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!sleep_req_i)     state_nxt = ST_ACTIVE;
        else if (idle_done)   state_nxt = ST_SLEEP;
        else if (timeout_hit) state_nxt = ST_ISOLATE;
      end
      ST_ISOLATE: state_nxt = ST_SLEEP;
      ST_SLEEP:   if (!sleep_req_i || incoming_req_i) state_nxt = ST_WAKE;
      ST_WAKE:    state_nxt = ST_ACTIVE;
      default:    state_nxt = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_ACTIVE;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      idle_cnt     <= '0;
      error_q      <= 1'b0;
      clock_down_q <= 1'b0;
      sleep_ack_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == ST_ISOLATE) begin
        // Forced isolation abandons whatever was in flight.
        wr_cnt  <= '0;
        rd_cnt  <= '0;
        error_q <= 1'b1;
      end else begin
        wr_cnt <= wr_step[CW-1:0];
        rd_cnt <= rd_step[CW-1:0];
        if (wr_step[CW] || rd_step[CW]) error_q <= 1'b1;
      end
      idle_cnt     <= ((state == ST_DRAIN) && idle) ? idle_cnt + 1'b1 : '0;
      clock_down_q <= (state_nxt == ST_SLEEP) || (state_nxt == ST_ISOLATE);
      sleep_ack_q  <= (state_nxt == ST_SLEEP);
    end
  end

  assign clock_down_o = clock_down_q;
  assign sleep_ack_o  = sleep_ack_q;
  assign wr_outst_o   = wr_cnt;
  assign rd_outst_o   = rd_cnt;
  assign error_o      = error_q;

endmodule

// File: tb/tb_axi_slice_dc_pwr_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for axi_slice_dc_pwr_ctrl. Table vectors for the counters, directed
// sequences for the power sequencing corners, then randomized traffic checked
// every cycle against a behavioural model. The timeout path is checked when
// AXI_SLICE_DC_PWR_CTRL_TIMEOUT_EN is defined for both files.
// -----------------------------------------------------------------------------
module tb_axi_slice_dc_pwr_ctrl;
  localparam int MAX = 15;
  localparam int IDLE = 8;
  localparam int TO = 16;
  localparam int CW = 4;
`ifdef AXI_SLICE_DC_PWR_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1, sreq = 1'b0, inc = 1'b0;
  logic aw = 1'b0, ar = 1'b0, b = 1'b0, rl = 1'b0;
  logic clock_down, isolate, sleep_ack, error;
  logic [CW-1:0] wr_outst, rd_outst;

  int checks = 0;
  int errors = 0;

  axi_slice_dc_pwr_ctrl #(.MAX_OUTST(MAX), .IDLE_CYCLES(IDLE), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst), .sleep_req_i(sreq), .incoming_req_i(inc),
    .aw_hs_i(aw), .ar_hs_i(ar), .b_hs_i(b), .r_last_hs_i(rl),
    .clock_down_o(clock_down), .isolate_o(isolate), .sleep_ack_o(sleep_ack),
    .wr_outst_o(wr_outst), .rd_outst_o(rd_outst), .error_o(error)
  );

  always #5 clk = ~clk;

  // Behavioural model: phases of the power sequence, plain integer counters.
  typedef enum int {M_RUN, M_DRAIN, M_ISO, M_SLEEP, M_WAKE} mph_t;
  mph_t ph = M_RUN;
  int   m_wr = 0, m_rd = 0, idle_run = 0, drain_len = 0;
  bit   m_err = 1'b0, via_iso = 1'b0;

  task automatic model_edge();
    bit idle;
    idle = !inc && (m_wr == 0) && (m_rd == 0);
    if (rst) begin
      ph = M_RUN; m_wr = 0; m_rd = 0; m_err = 0; via_iso = 0;
      idle_run = 0; drain_len = 0;
      return;
    end
    if (aw && !b)      begin if (m_wr == MAX) m_err = 1; else m_wr++; end
    else if (b && !aw) begin if (m_wr == 0)   m_err = 1; else m_wr--; end
    if (ar && !rl)      begin if (m_rd == MAX) m_err = 1; else m_rd++; end
    else if (rl && !ar) begin if (m_rd == 0)   m_err = 1; else m_rd--; end
    case (ph)
      M_RUN: if (sreq) begin ph = M_DRAIN; idle_run = 0; drain_len = 0; end
      M_DRAIN: begin
        if (!sreq) ph = M_RUN;
        else begin
          drain_len++;
          idle_run = idle ? idle_run + 1 : 0;
          if (idle_run >= IDLE) begin ph = M_SLEEP; via_iso = 0; end
          else if (TO_EN && drain_len >= TO) begin
            ph = M_ISO; m_wr = 0; m_rd = 0; m_err = 1;
          end
        end
      end
      M_ISO:   begin ph = M_SLEEP; via_iso = 1; end
      M_SLEEP: if (!sreq || inc) ph = M_WAKE;
      default: ph = M_RUN;
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("m_wr_outst",   wr_outst,   m_wr);
    chk("m_rd_outst",   rd_outst,   m_rd);
    chk("m_error",      error,      m_err);
    chk("m_clock_down", clock_down, (ph == M_SLEEP) || (ph == M_ISO));
    chk("m_sleep_ack",  sleep_ack,  ph == M_SLEEP);
    chk("m_isolate",    isolate,    (ph == M_ISO) || ((ph == M_SLEEP) && via_iso));
  endtask

  task automatic clr_in();
    sreq = 0; inc = 0; aw = 0; ar = 0; b = 0; rl = 0;
  endtask

  task automatic do_reset();
    clr_in(); rst = 1; step(); rst = 0;
  endtask

  task automatic wait_sleep(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (sleep_ack) begin n = i; break; end
    end
  endtask

  typedef struct {
    bit aw, ar, b, rl;
    int wr, rd;
    bit err;
  } vec_t;
  vec_t vecs[13];

  initial begin
    int n;
    vecs[0]  = '{1,0,0,0, 1,0,0};
    vecs[1]  = '{1,0,0,0, 2,0,0};
    vecs[2]  = '{0,1,0,0, 2,1,0};
    vecs[3]  = '{0,1,0,0, 2,2,0};
    vecs[4]  = '{0,1,0,1, 2,2,0};
    vecs[5]  = '{1,0,1,0, 2,2,0};
    vecs[6]  = '{0,0,1,1, 1,1,0};
    vecs[7]  = '{0,0,1,0, 0,1,0};
    vecs[8]  = '{0,0,0,1, 0,0,0};
    vecs[9]  = '{1,1,0,0, 1,1,0};
    vecs[10] = '{0,0,1,1, 0,0,0};
    vecs[11] = '{0,0,0,1, 0,0,1};
    vecs[12] = '{0,0,1,0, 0,0,1};

    rst = 1; step(); step();
    chk("rst_clock_down", clock_down, 0);
    chk("rst_outst", {wr_outst, rd_outst}, 0);
    rst = 0; step();
    chk("post_rst_clock_down", clock_down, 0);

    // Counter vectors
    for (int i = 0; i < 13; i++) begin
      aw = vecs[i].aw; ar = vecs[i].ar; b = vecs[i].b; rl = vecs[i].rl;
      step();
      chk($sformatf("vec%0d_wr", i),  wr_outst, vecs[i].wr);
      chk($sformatf("vec%0d_rd", i),  rd_outst, vecs[i].rd);
      chk($sformatf("vec%0d_err", i), error,    vecs[i].err);
    end

    // Saturation at MAX_OUTST
    do_reset();
    aw = 1;
    for (int i = 0; i < MAX; i++) step();
    chk("sat_wr_full", wr_outst, MAX);
    chk("sat_no_err", error, 0);
    step();
    chk("sat_wr_hold", wr_outst, MAX);
    chk("sat_err", error, 1);
    b = 1; step(); clr_in();
    chk("sat_both_hold", wr_outst, MAX);

    // Sleep with no traffic: 8 DRAIN cycles, SLEEP on the 9th step
    do_reset();
    sreq = 1;
    wait_sleep(20, n);
    chk("sleep_latency", n, 9);
    chk("sleep_clock_down", clock_down, 1);

    // Wake on incoming request, re-drain while sleep_req held
    inc = 1; step(); inc = 0;
    chk("wake_clock_down", clock_down, 0);
    chk("wake_ack", sleep_ack, 0);
    step();
    chk("wake_active_clock_down", clock_down, 0);
    wait_sleep(20, n);
    chk("resleep_latency", n, 9);

    // Reset in SLEEP
    rst = 1; step(); rst = 0;
    chk("rst_sleep_outputs", {clock_down, isolate, sleep_ack, error}, 0);
    sreq = 0;

    // Drain with outstanding writes
    do_reset();
    aw = 1; step(); step(); step(); aw = 0;
    chk("drain_wr3", wr_outst, 3);
    sreq = 1;
    for (int k = 0; k < 3; k++) begin
      repeat (4) step();
      chk("drain_not_asleep", sleep_ack, 0);
      b = 1; step(); b = 0;
      chk($sformatf("drain_wr_after_b%0d", k), wr_outst, 2 - k);
    end
    wait_sleep(20, n);
    chk("drain_sleep_after_last_b", n, 8);

    // Unanswered read with sleep requested
    do_reset();
    ar = 1; step(); ar = 0;
    sreq = 1;
`ifdef AXI_SLICE_DC_PWR_CTRL_TIMEOUT_EN
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (isolate) begin n = i; break; end
    end
    chk("timeout_latency", n, TO + 1);
    chk("iso_clock_down", clock_down, 1);
    chk("iso_rd_cleared", rd_outst, 0);
    chk("iso_err", error, 1);
    step();
    chk("iso_sleep_ack", sleep_ack, 1);
    chk("iso_sleep_isolate", isolate, 1);
`else
    repeat (40) step();
    chk("no_timeout_ack", sleep_ack, 0);
    chk("no_timeout_isolate", isolate, 0);
    chk("no_timeout_rd", rd_outst, 1);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 39) == 0) sreq = ~sreq;
      inc = ($urandom_range(0, 24) == 0);
      aw  = ($urandom_range(0, 9) == 0);
      ar  = ($urandom_range(0, 9) == 0);
      b   = (m_wr > 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 99) == 0);
      rl  = (m_rd > 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
